// File: rtl/ibex_trace_buffer.sv
// Retirement trace buffer for ibex: captures RVFI records into a circular store with FIFO,
// overwrite and trigger-window capture modes. IBEX_TRACE_BUF_DROP_CNT_EN enables the drop counter.
module ibex_trace_buffer #(
  parameter int unsigned Depth         = 16,
  parameter int unsigned PostTrigCount = 8,
  parameter bit          CaptureWdata  = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [1:0]                 mode_i,
  input  logic                       clear_i,
  input  logic                       trig_en_i,
  input  logic [31:0]                trig_pc_i,
  input  logic                       rvfi_valid,
  input  logic [31:0]                rvfi_pc_rdata,
  input  logic [31:0]                rvfi_insn,
  input  logic [4:0]                 rvfi_rd_addr,
  input  logic [31:0]                rvfi_rd_wdata,
  input  logic                       rvfi_trap,
  input  logic                       rvfi_intr,
  input  logic [1:0]                 rvfi_mode,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_pc_o,
  output logic [31:0]                out_insn_o,
  output logic [31:0]                out_rd_wdata_o,
  output logic [4:0]                 out_rd_addr_o,
  output logic [3:0]                 out_flags_o,
  output logic [$clog2(Depth):0]     level_o,
  output logic                       triggered_o,
  output logic                       frozen_o,
  output logic [15:0]                drop_cnt_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [3:0]  flags;
    logic [4:0]  rd_addr;
    logic [31:0] wdata;
    logic [31:0] insn;
    logic [31:0] pc;
  } rec_t;

  localparam int unsigned RecW = $bits(rec_t);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_POST   = 2'd1,
    ST_FROZEN = 2'd2
  } state_e;

  rec_t              mem_r [Depth];
  logic [PtrW-1:0]   wr_ptr_r;
  logic [PtrW-1:0]   rd_ptr_r;
  logic [CntW-1:0]   count_r;
  logic [CntW-1:0]   post_cnt_r;
  state_e            state_r;
  logic              triggered_r;
  logic              frozen_r;

  rec_t              rec_s;
  logic              full_s;
  logic              empty_s;
  logic              pop_s;
  logic              push_s;
  logic              ovw_mode_s;
  logic              wr_en_s;
  logic              rd_adv_s;
  logic              trig_hit_s;

  // Build the record to be stored from the retirement port.
  always_comb begin
    rec_s         = {RecW{1'b0}};
    rec_s.pc      = rvfi_pc_rdata;
    rec_s.insn    = rvfi_insn;
    rec_s.rd_addr = rvfi_rd_addr;
    rec_s.flags   = {rvfi_mode, rvfi_intr, rvfi_trap};
    if (CaptureWdata) begin
      rec_s.wdata = rvfi_rd_wdata;
    end else begin
      rec_s.wdata = 32'h0;
    end
  end

  // Push/pop decode; when full in overwrite modes the write slot equals the head slot.
  always_comb begin
    full_s     = (count_r == CntW'(Depth));
    empty_s    = (count_r == {CntW{1'b0}});
    pop_s      = !empty_s && out_ready_i;
    ovw_mode_s = (mode_i == 2'd1) || (mode_i == 2'd2);
    push_s     = rvfi_valid && (mode_i != 2'd3) &&
                 !((mode_i == 2'd2) && (state_r == ST_FROZEN));
    wr_en_s    = push_s && (!full_s || pop_s || ovw_mode_s);
    rd_adv_s   = pop_s || (push_s && full_s && !pop_s && ovw_mode_s);
    trig_hit_s = rvfi_trap || (trig_en_i && (rvfi_pc_rdata == trig_pc_i));
  end

  // Record storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_r[i] <= {RecW{1'b0}};
      end
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      count_r  <= {CntW{1'b0}};
    end else if (clear_i) begin
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      count_r  <= {CntW{1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= rec_s;
        wr_ptr_r        <= wr_ptr_r + PtrW'(1);
      end
      if (rd_adv_s) begin
        rd_ptr_r <= rd_ptr_r + PtrW'(1);
      end
      if (wr_en_s && !pop_s && !full_s) begin
        count_r <= count_r + CntW'(1);
      end else if (pop_s && !wr_en_s) begin
        count_r <= count_r - CntW'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Trigger-window state machine; only active while mode 2 is selected.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_RUN;
      triggered_r <= 1'b0;
      frozen_r    <= 1'b0;
      post_cnt_r  <= {CntW{1'b0}};
    end else if (clear_i || (mode_i != 2'd2)) begin
      state_r     <= ST_RUN;
      triggered_r <= 1'b0;
      frozen_r    <= 1'b0;
      post_cnt_r  <= {CntW{1'b0}};
    end else begin
      case (state_r)
        ST_RUN: begin
          if (wr_en_s && trig_hit_s) begin
            state_r     <= ST_POST;
            triggered_r <= 1'b1;
            post_cnt_r  <= CntW'(PostTrigCount);
          end
        end
        ST_POST: begin
          if (wr_en_s) begin
            post_cnt_r <= post_cnt_r - CntW'(1);
            if (post_cnt_r == CntW'(1)) begin
              state_r  <= ST_FROZEN;
              frozen_r <= 1'b1;
            end
          end
        end
        ST_FROZEN: begin
          state_r <= ST_FROZEN;
        end
        default: begin
          state_r  <= ST_RUN;
          frozen_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef IBEX_TRACE_BUF_DROP_CNT_EN
  logic        drop_s;
  logic [15:0] drop_cnt_r;

  // Both discarded records (mode 0) and overwritten records (modes 1/2) count as drops.
  assign drop_s = push_s && full_s && !pop_s;

  // Saturating drop counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_r <= 16'h0;
    end else if (clear_i) begin
      drop_cnt_r <= 16'h0;
    end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'h1;
    end
  end

  assign drop_cnt_o = drop_cnt_r;
`else
  assign drop_cnt_o = 16'h0;
`endif

  assign out_valid_o    = !empty_s;
  assign out_pc_o       = mem_r[rd_ptr_r].pc;
  assign out_insn_o     = mem_r[rd_ptr_r].insn;
  assign out_rd_wdata_o = mem_r[rd_ptr_r].wdata;
  assign out_rd_addr_o  = mem_r[rd_ptr_r].rd_addr;
  assign out_flags_o    = mem_r[rd_ptr_r].flags;
  assign level_o        = count_r;
  assign triggered_o    = triggered_r;
  assign frozen_o       = frozen_r;

endmodule
